irq_dispatch: RTL and testbench
===============================

# irq_dispatch

Registers the winner chosen by the priority comparator tree and decides whether it may interrupt the core. It holds a nesting stack of active priority levels and runs a valid/ready offer handshake toward the core. On acceptance it pulses a pending-clear back to the per-source pending registers that feed the tree. It sits directly downstream of the tree and upstream of the core's trap entry.

## Interface
Parameters:
- `Width`, 8: number of interrupt sources; equals the tree width, power of two.
- `PrioWidth`, 8: priority width; value 0 means "not pending or masked".
- `StackDepth`, 4: maximum nesting depth; must be at least 1.
- `IdxWidth`, `$clog2(Width)`: source index width.

Ports:
- `clk` in 1: the block's one clock.
- `reset` in 1: asynchronous, active-high reset.
- `prio` in `PrioWidth` x `Width`: effective priority per source (the same array fed to the tree).
- `win_idx` in `IdxWidth`: winning index from the tree, combinational from `prio`.
- `irq_valid` out 1: offer to the core.
- `irq_id` out `IdxWidth`: offered source index.
- `irq_prio` out `PrioWidth`: offered priority.
- `irq_ready` in 1: core accepts the offer.
- `complete` in 1: core finished the innermost handler (one-cycle pulse).
- `clr_valid` out 1: pending-clear pulse to upstream.
- `clr_id` out `IdxWidth`: source to clear.
- `level` out `PrioWidth`: current running level; top of stack, or 0 when the stack is empty.
- `depth` out `$clog2(StackDepth+1)`: number of stack entries.
- `err_underflow` out 1: sticky; set by `complete` while the stack is empty.

## Operation
- Candidate register: every cycle, `cand_id <= win_idx` and `cand_prio <= prio[win_idx]`. It is held frozen while in OFFER.
- Eligibility: `cand_prio != 0`, `cand_prio > level` (unsigned, strict), and `depth < StackDepth`. A tie with `level` never preempts.
- FSM states and transitions:
  - IDLE:
    - When the candidate is eligible, go to OFFER and latch `irq_id`/`irq_prio` from the candidate.
  - OFFER:
    - `irq_valid=1`.
    - `irq_id`/`irq_prio` stay stable until `irq_ready`. An offer is never withdrawn, even if the source's `prio` drops.
    - On `irq_ready`: push `irq_prio`, go to SETTLE1.
  - SETTLE1:
    - `clr_valid=1`, `clr_id=irq_id`.
    - Go to SETTLE2.
  - SETTLE2:
    - Idle blanking cycle while upstream pending and the candidate register refresh.
    - Go to IDLE.
- `complete`:
  - Pops the stack in any state.
  - With an empty stack it is ignored and sets `err_underflow`.
- `complete` and handshake (`irq_valid & irq_ready`) in the same cycle: pop first, then push. `depth` is unchanged and the top entry becomes `irq_prio`.
- Stack full (`depth == StackDepth`): no new offers; an offer already in OFFER is still honoured only if a simultaneous `complete` frees a slot. Otherwise `irq_ready` is ignored until one does.
- The `level` decrease after a pop takes effect for the eligibility check on the next cycle.

## Timing
- Reset values:
  - FSM enters IDLE.
  - `irq_valid=0`, `irq_id=0`, `irq_prio=0`.
  - `clr_valid=0`, `clr_id=0`.
  - Stack empty: `level=0`, `depth=0`.
  - `err_underflow=0`.
  - Candidate registers 0.
- Reset mid-OFFER or mid-SETTLE drops the offer and the stack immediately (asynchronous); no `clr_valid` is issued.
- Latency, from `prio` change in cycle t (IDLE, eligible):
  - `irq_valid` high in cycle t+2.
- Handshake accepted in cycle a:
  - `clr_valid` high in cycle a+1 only.
  - `depth`/`level` updated in cycle a+1.
  - Earliest next `irq_valid` in cycle a+4.
- `irq_valid` is a registered output; the block has no combinational path from `irq_ready` to any output.

## Configuration
- `NCLIC_NEST_EN` defined:
  - The stack has `StackDepth` entries.
  - A higher-priority candidate preempts the running level.
- Not defined:
  - The effective depth is 1 and `StackDepth` is ignored.
  - An offer is made only when `depth==0`.
  - `level` is either 0 or the priority of the single active handler; there is no preemption.

## Test plan
- Reset then `prio[5]=3`, `win_idx=5` at cycle 0 -> `irq_valid=1`, `irq_id=5`, `irq_prio=3` at cycle 2. Holding `irq_ready=0` for 10 cycles keeps the offer stable.
- Accept at cycle a -> `clr_valid=1`, `clr_id=5` at a+1 only; `level=3`, `depth=1`. Then `complete` -> `level=0`, `depth=0`.
- Nesting (macro on, depth 4):
  - Running level 3; `prio[2]=7` -> offer id 2.
  - `prio[1]=3` -> no offer (tie).
  - Four accepted nested offers at 4, 5, 6, 8 -> a fifth candidate at 9 is not offered until a `complete`.
- Simultaneous `complete` and `irq_ready` with `depth=2`, stack {3,5}, offer prio 6 -> `depth=2`, `level=6`.
- `complete` with an empty stack -> `depth` stays 0 and `err_underflow=1` until reset.
- Macro off: `level=3`, then candidate prio 7 -> no `irq_valid` until `complete`; then offered within 3 cycles.

Source files
------------

// File: rtl/irq_dispatch.sv
// irq_dispatch: registers the tree winner, offers it to the core over valid/ready and tracks nesting levels.
// Define NCLIC_NEST_EN for a StackDepth-deep preemption stack; otherwise a single active handler.
module irq_dispatch #(
  parameter int Width = 8,
  parameter int PrioWidth = 8,
  parameter int StackDepth = 4,
  parameter int IdxWidth = $clog2(Width)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [Width-1:0][PrioWidth-1:0]    prio,
  input  logic [IdxWidth-1:0]                win_idx,
  output logic                               irq_valid,
  output logic [IdxWidth-1:0]                irq_id,
  output logic [PrioWidth-1:0]               irq_prio,
  input  logic                               irq_ready,
  input  logic                               complete,
  output logic                               clr_valid,
  output logic [IdxWidth-1:0]                clr_id,
  output logic [PrioWidth-1:0]               level,
  output logic [$clog2(StackDepth+1)-1:0]    depth,
  output logic                               err_underflow
);
  localparam int DepthW = $clog2(StackDepth + 1);
`ifdef NCLIC_NEST_EN
  localparam int Eff = StackDepth;
`else
  localparam int Eff = 1;
`endif
  typedef enum logic [1:0] {IDLE, OFFER, SETTLE1, SETTLE2} state_t;
  state_t state, state_d;
  logic [IdxWidth-1:0] cand_id;
  logic [PrioWidth-1:0] cand_prio;
  logic [PrioWidth-1:0] stk [Eff];
  logic full, eligible, load, accept, pop;
  logic [DepthW-1:0] wr;
  always_comb begin
    level = '0;
    for (int i = 0; i < Eff; i++) level = (depth == DepthW'(i + 1)) ? stk[i] : level;
  end
  assign full = depth == DepthW'(Eff);
  assign eligible = cand_prio != '0 && cand_prio > level && !full;
  assign pop = complete && depth != '0;
  // a pop in the same cycle frees the slot the push lands in
  assign accept = state == OFFER && irq_ready && (!full || pop);
  assign wr = depth - DepthW'(pop);
  assign irq_valid = state == OFFER;
  assign clr_valid = state == SETTLE1;
  assign clr_id = irq_id;
  always_comb begin
    load = state == IDLE && eligible;
    state_d = state == IDLE    ? (eligible ? OFFER : IDLE) :
              state == OFFER   ? (accept ? SETTLE1 : OFFER) :
              state == SETTLE1 ? SETTLE2 : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cand_id <= '0;
      cand_prio <= '0;
      irq_id <= '0;
      irq_prio <= '0;
      depth <= '0;
      err_underflow <= 1'b0;
      for (int i = 0; i < Eff; i++) stk[i] <= '0;
    end else begin
      state <= state_d;
      if (state != OFFER) begin
        cand_id <= win_idx;
        cand_prio <= prio[win_idx];
      end
      if (load) begin
        irq_id <= cand_id;
        irq_prio <= cand_prio;
      end
      if (complete && depth == '0) err_underflow <= 1'b1;
      if (accept)
        for (int i = 0; i < Eff; i++) if (wr == DepthW'(i)) stk[i] <= irq_prio;
      depth <= depth + DepthW'(accept) - DepthW'(pop);
    end
  end
endmodule

// File: tb/tb_irq_dispatch.sv
// tb_irq_dispatch: table vectors, directed nesting/reset sequences and a randomized run against a queue-based model.
module tb_irq_dispatch;
  localparam int W = 8, PW = 8, SD = 4, IW = 3, DW = $clog2(SD + 1);
`ifdef NCLIC_NEST_EN
  localparam int EFF = SD;
`else
  localparam int EFF = 1;
`endif
  logic clk = 0, reset = 1;
  logic [W-1:0][PW-1:0] prio = '0;
  logic [IW-1:0] win_idx = '0;
  logic irq_valid, irq_ready = 0, complete = 0, clr_valid, err_underflow;
  logic [IW-1:0] irq_id, clr_id;
  logic [PW-1:0] irq_prio, level;
  logic [DW-1:0] depth;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  irq_dispatch #(.Width(W), .PrioWidth(PW), .StackDepth(SD)) dut (
    .clk(clk), .reset(reset), .prio(prio), .win_idx(win_idx),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_prio(irq_prio), .irq_ready(irq_ready),
    .complete(complete), .clr_valid(clr_valid), .clr_id(clr_id), .level(level),
    .depth(depth), .err_underflow(err_underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] argmax(input logic [W-1:0][PW-1:0] p);
    int b = 0;
    for (int i = 1; i < W; i++) if (p[i] > p[b]) b = i;
    return IW'(b);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int src, input int val);
    prio = '0;
    prio[IW'(src)] = PW'(val);
    win_idx = argmax(prio);
  endtask

  task automatic do_reset();
    reset = 1;
    irq_ready = 0;
    complete = 0;
    setp(0, 0);
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic wait_offer(output int n);
    n = 0;
    while (!irq_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("offer_seen", int'(irq_valid), 1);
  endtask

  // accept one offer of source src at priority val, then clear its pending bit
  task automatic take(input int src, input int val);
    int n;
    setp(src, val);
    wait_offer(n);
    irq_ready = 1;
    cyc();
    irq_ready = 0;
    setp(src, 0);
    cyc();
    cyc();
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (irq_valid) n++;
    end
  endtask

  typedef struct {
    int src, val;
    bit rdy, cmp;
    bit ev;
    int eid, ep;
    bit ec;
    int el, ed;
    bit ee;
  } vec_t;
  vec_t tbl[16];

  int q[$];
  bit m_off, m_err;
  int m_oid, m_op, m_blank, m_cid, m_cp;

  task automatic model_step();
    int lvl;
    bit was_off, pop, acc, elig;
    lvl = q.size() != 0 ? q[$] : 0;
    was_off = m_off;
    pop = complete && q.size() != 0;
    acc = m_off && irq_ready && (q.size() < EFF || pop);
    elig = !m_off && m_blank == 0 && m_cp != 0 && m_cp > lvl && q.size() < EFF;
    if (complete && q.size() == 0) m_err = 1;
    if (pop) void'(q.pop_back());
    if (acc) q.push_back(m_op);
    if (m_blank > 0) m_blank--;
    if (acc) begin
      m_off = 0;
      m_blank = 2;
    end else if (elig) begin
      m_off = 1;
      m_oid = m_cid;
      m_op = m_cp;
    end
    if (!was_off) begin
      m_cid = int'(win_idx);
      m_cp = int'(prio[win_idx]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{5, 3, 0, 0, 1, 5, 3, 0, 0, 0, 0};
    tbl[3]  = '{5, 3, 0, 0, 1, 5, 3, 0, 0, 0, 0};
    tbl[4]  = '{5, 3, 1, 0, 1, 5, 3, 0, 0, 0, 0};
    tbl[5]  = '{5, 0, 0, 0, 0, 5, 3, 1, 3, 1, 0};
    tbl[6]  = '{5, 0, 0, 0, 0, 5, 3, 0, 3, 1, 0};
    tbl[7]  = '{5, 0, 0, 0, 0, 5, 3, 0, 3, 1, 0};
    tbl[8]  = '{5, 0, 0, 1, 0, 5, 3, 0, 3, 1, 0};
    tbl[9]  = '{5, 0, 0, 0, 0, 5, 3, 0, 0, 0, 0};
    tbl[10] = '{2, 7, 0, 0, 0, 5, 3, 0, 0, 0, 0};
    tbl[11] = '{2, 7, 0, 0, 0, 5, 3, 0, 0, 0, 0};
    tbl[12] = '{2, 7, 0, 0, 1, 2, 7, 0, 0, 0, 0};
    tbl[13] = '{2, 7, 1, 1, 1, 2, 7, 0, 0, 0, 0};
    tbl[14] = '{2, 0, 0, 0, 0, 2, 7, 1, 7, 1, 1};
    tbl[15] = '{2, 0, 0, 0, 0, 2, 7, 0, 7, 1, 1};

    do_reset();
    for (int k = 0; k < 16; k++) begin
      setp(tbl[k].src, tbl[k].val);
      irq_ready = tbl[k].rdy;
      complete = tbl[k].cmp;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", k), int'(irq_valid), int'(tbl[k].ev));
      chk($sformatf("tbl%0d_id", k), int'(irq_id), tbl[k].eid);
      chk($sformatf("tbl%0d_prio", k), int'(irq_prio), tbl[k].ep);
      chk($sformatf("tbl%0d_clr", k), int'(clr_valid), int'(tbl[k].ec));
      if (tbl[k].ec) chk($sformatf("tbl%0d_clr_id", k), int'(clr_id), tbl[k].eid);
      chk($sformatf("tbl%0d_level", k), int'(level), tbl[k].el);
      chk($sformatf("tbl%0d_depth", k), int'(depth), tbl[k].ed);
      chk($sformatf("tbl%0d_err", k), int'(err_underflow), int'(tbl[k].ee));
      @(posedge clk);
      #1;
    end
    irq_ready = 0;
    complete = 0;

    // offer held stable for 10 cycles, even after the source drops
    do_reset();
    chk("err_cleared_by_reset", int'(err_underflow), 0);
    setp(5, 3);
    cyc();
    cyc();
    for (int k = 0; k < 10; k++) begin
      if (k == 4) setp(5, 0);
      @(negedge clk);
      chk("hold_valid", int'(irq_valid), 1);
      chk("hold_id", int'(irq_id), 5);
      chk("hold_prio", int'(irq_prio), 3);
      cyc();
    end
    @(negedge clk);
    reset = 1;
    #1;
    chk("async_rst_valid", int'(irq_valid), 0);
    chk("async_rst_clr", int'(clr_valid), 0);
    chk("async_rst_depth", int'(depth), 0);
    do_reset();

`ifdef NCLIC_NEST_EN
    take(1, 3);
    take(2, 5);
    setp(3, 6);
    wait_offer(n);
    irq_ready = 1;
    complete = 1;
    cyc();
    irq_ready = 0;
    complete = 0;
    chk("pop_push_depth", int'(depth), 2);
    chk("pop_push_level", int'(level), 6);
    chk("pop_push_clr", int'(clr_valid), 1);
    do_reset();
    take(5, 3);
    setp(1, 3);
    count_valid(6, n);
    chk("tie_no_offer", n, 0);
    setp(2, 7);
    wait_offer(n);
    chk("preempt_id", int'(irq_id), 2);
    do_reset();
    take(1, 2);
    take(2, 3);
    take(3, 4);
    take(4, 5);
    chk("full_depth", int'(depth), 4);
    setp(6, 7);
    count_valid(6, n);
    chk("full_no_offer", n, 0);
    complete = 1;
    cyc();
    complete = 0;
    wait_offer(n);
    chk("after_full_id", int'(irq_id), 6);
`else
    take(5, 3);
    chk("single_level", int'(level), 3);
    chk("single_depth", int'(depth), 1);
    setp(2, 7);
    count_valid(6, n);
    chk("no_preempt", n, 0);
    complete = 1;
    cyc();
    complete = 0;
    n = 0;
    while (!irq_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("reoffer_latency", n, 1);
    chk("reoffer_id", int'(irq_id), 2);
`endif

    do_reset();
    q.delete();
    m_off = 0; m_err = 0; m_oid = 0; m_op = 0; m_blank = 0; m_cid = 0; m_cp = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < W; i++) prio[i] = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(1, 9)) : '0;
      if (m_blank == 2) prio[IW'(m_oid)] = '0;
      win_idx = argmax(prio);
      irq_ready = $urandom_range(0, 2) != 0;
      complete = $urandom_range(0, 11) == 0;
      @(negedge clk);
      chk("rnd_valid", int'(irq_valid), int'(m_off));
      chk("rnd_id", int'(irq_id), m_oid);
      chk("rnd_prio", int'(irq_prio), m_op);
      chk("rnd_clr", int'(clr_valid), int'(m_blank == 2));
      if (m_blank == 2) chk("rnd_clr_id", int'(clr_id), m_oid);
      chk("rnd_level", int'(level), q.size() != 0 ? q[$] : 0);
      chk("rnd_depth", int'(depth), q.size());
      chk("rnd_err", int'(err_underflow), int'(m_err));
      model_step();
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
